// File: rtl/shapes_pkg.sv
// Shared types and constants for the shape-generator pixel path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shapes_pkg;

    localparam int N    = 10;   // coordinate width
    localparam int NPTS = 8;    // points per bundle
    localparam int AW   = 19;   // frame-buffer address width
    localparam int CW   = 8;    // pixel colour width

    // Screen limits carried at coordinate width so bound checks compare like with like.
    localparam logic [N-1:0] XMAX = N'(640);
    localparam logic [N-1:0] YMAX = N'(480);

    // x occupies the upper half of a packed point, y the lower half.
    typedef struct packed {
        logic [N-1:0] x;
        logic [N-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } ser_state_t;

endpackage

// File: rtl/pt_addr.sv
// Screen bounds check and frame-buffer address for one point.
// Latency: combinational.
// Backpressure: none.
// Ports: pt (point in), in_bounds (x<XMAX and y<YMAX), addr (y*XMAX+x, AW bits).
module pt_addr
    import shapes_pkg::*;
(
    input  point_t        pt,
    output logic          in_bounds,
    output logic [AW-1:0] addr
);

    assign in_bounds = (pt.x < XMAX) && (pt.y < YMAX);

    // Modular AW-bit arithmetic yields exactly the low AW bits of the
    // full-width product-sum, so no wider intermediate is needed.
    assign addr = AW'(pt.y) * AW'(XMAX) + AW'(pt.x);

endmodule

// File: rtl/pts_serializer.sv
// Serialises a bundle of up to 8 points into one pixel write per cycle,
// dropping back-to-back duplicates and off-screen points, with per-bundle stats.
// Latency: first write/skip one cycle after acceptance; K points + 1 done cycle.
// Backpressure: in_ready low outside IDLE; wr_ready=0 holds the current write stable.
// Ports: clk/rst; in_valid/in_ready/posiciones/count/color (bundle in);
//        wr_en/wr_ready/wr_addr/wr_data (pixel write out);
//        busy, done, clip_cnt, dup_cnt (status, counters valid while done=1).
module pts_serializer
    import shapes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*N*NPTS-1:0]   posiciones,
    input  logic [3:0]            count,
    input  logic [CW-1:0]         color,
    output logic                  wr_en,
    input  logic                  wr_ready,
    output logic [AW-1:0]         wr_addr,
    output logic [CW-1:0]         wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            clip_cnt,
    output logic [3:0]            dup_cnt
);

    ser_state_t          state_q, state_d;
    logic [2*N*NPTS-1:0] pos_q;
    logic [3:0]          cnt_q;
    logic [CW-1:0]       color_q;
    logic [2:0]          idx_q, idx_d;
    logic [3:0]          clip_q, clip_d;
    logic [3:0]          dup_q, dup_d;
    logic                capture;

    logic [3:0]          sat_count;
    logic [2:0]          prev_idx;
    point_t              cur_pt, prev_pt;
    logic                cur_in_bounds;
    logic [AW-1:0]       cur_addr;
    logic                is_dup;
    logic                advance;

    assign sat_count = (count > 4'd8) ? 4'd8 : count;

    // Only captured registers feed the write path; in_* never reach wr_*.
    assign prev_idx = idx_q - 3'd1;
    assign cur_pt   = pos_q[idx_q*(2*N) +: 2*N];
    assign prev_pt  = pos_q[prev_idx*(2*N) +: 2*N];
    // Compared against the raw previous point, whether or not it was written.
    assign is_dup   = (idx_q != 3'd0) && (cur_pt == prev_pt);

    pt_addr u_pt_addr (
        .pt        (cur_pt),
        .in_bounds (cur_in_bounds),
        .addr      (cur_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            cnt_q   <= '0;
            color_q <= '0;
            idx_q   <= '0;
            clip_q  <= '0;
            dup_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            clip_q  <= clip_d;
            dup_q   <= dup_d;
            if (capture) begin
                pos_q   <= posiciones;
                cnt_q   <= sat_count;
                color_q <= color;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clip_d   = clip_q;
        dup_d    = dup_q;
        capture  = 1'b0;
        advance  = 1'b0;
        in_ready = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    clip_d  = '0;
                    dup_d   = '0;
                    state_d = (sat_count == 4'd0) ? DONE : EMIT;
                end
            end
            EMIT: begin
                if (is_dup) begin
                    dup_d   = dup_q + 4'd1;
                    advance = 1'b1;
                end else if (!cur_in_bounds) begin
                    clip_d  = clip_q + 4'd1;
                    advance = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = cur_addr;
                    wr_data = color_q;
                    advance = wr_ready;
                end
                if (advance) begin
                    if ({1'b0, idx_q} == cnt_q - 4'd1) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign clip_cnt = clip_q;
    assign dup_cnt  = dup_q;

endmodule

// File: tb/tb_pts_serializer.sv
// Directed bench for pts_serializer: hand-computed addresses, counters and timing.
// Latency: n/a.
// Backpressure: wr_ready driven by the bench to create stalls.
module tb_pts_serializer;
    import shapes_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [2*N*NPTS-1:0] posiciones;
    logic [3:0]          count;
    logic [CW-1:0]       color;
    logic                wr_en;
    logic                wr_ready;
    logic [AW-1:0]       wr_addr;
    logic [CW-1:0]       wr_data;
    logic                busy;
    logic                done;
    logic [3:0]          clip_cnt;
    logic [3:0]          dup_cnt;

    int                  total = 0;
    int                  bad = 0;
    int                  nwr;
    int                  done_at;
    logic [AW-1:0]       last_addr;
    logic [AW-1:0]       stall_addr;

    pts_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .posiciones (posiciones),
        .count      (count),
        .color      (color),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .clip_cnt   (clip_cnt),
        .dup_cnt    (dup_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic setpt(input int k, input int x, input int y);
        posiciones[k*(2*N) +: 2*N] = {N'(x), N'(y)};
    endtask

    // Called with in_valid already high on an idle DUT; cycle 1 is the first
    // cycle after the accepting edge. wr_ready is low for cycles
    // [stall_from, stall_from+stall_len), during which the write must hold.
    task automatic run(input int stall_from, input int stall_len);
        nwr     = 0;
        done_at = -1;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            wr_ready = (c >= stall_from && c < stall_from + stall_len) ? 1'b0 : 1'b1;
            if (!wr_ready) begin
                chk("stall_wr_en", 32'(wr_en), 32'd1);
                chk("stall_wr_addr", 32'(wr_addr), 32'(stall_addr));
            end
            if (wr_en && wr_ready) begin
                nwr++;
                last_addr = wr_addr;
            end
            if (done) done_at = c;
        end
        wr_ready = 1'b1;
    endtask

    initial begin
        int exp1 [4];
        exp1 = '{12810, 13451, 14092, 14733};

        rst        = 1'b1;
        in_valid   = 1'b0;
        posiciones = '0;
        count      = '0;
        color      = '0;
        wr_ready   = 1'b1;
        stall_addr = '0;
        last_addr  = '0;

        // Reset values
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wr_en",    32'(wr_en),    32'd0);
        chk("rst_wr_addr",  32'(wr_addr),  32'd0);
        chk("rst_wr_data",  32'(wr_data),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_clip",     32'(clip_cnt), 32'd0);
        chk("rst_dup",      32'(dup_cnt),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Four in-range points written on consecutive cycles
        for (int k = 0; k < 4; k++) setpt(k, 10 + k, 20 + k);
        count    = 4'd4;
        color    = 8'h3C;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("t1_wr_en",   32'(wr_en),    32'd1);
            chk("t1_wr_addr", 32'(wr_addr),  32'(exp1[k]));
            chk("t1_wr_data", 32'(wr_data),  32'h3C);
            chk("t1_ready",   32'(in_ready), 32'd0);
        end
        @(negedge clk);
        chk("t1_done", 32'(done),     32'd1);
        chk("t1_busy", 32'(busy),     32'd1);
        chk("t1_clip", 32'(clip_cnt), 32'd0);
        chk("t1_dup",  32'(dup_cnt),  32'd0);
        chk("t1_wr_en_done", 32'(wr_en), 32'd0);
        @(negedge clk);
        chk("t1_ready_again", 32'(in_ready), 32'd1);
        chk("t1_done_pulse",  32'(done),     32'd0);

        // All eight points identical; count=15 saturates to 8
        for (int k = 0; k < 8; k++) setpt(k, 100, 100);
        count    = 4'd15;
        color    = 8'hA5;
        in_valid = 1'b1;
        run(0, 0);
        chk("t2_writes",  32'(nwr),       32'd1);
        chk("t2_addr",    32'(last_addr), 32'd64100);
        chk("t2_dup",     32'(dup_cnt),   32'd7);
        chk("t2_clip",    32'(clip_cnt),  32'd0);
        chk("t2_done_at", 32'(done_at),   32'd9);
        @(negedge clk);

        // Screen-edge clipping
        posiciones = '0;
        setpt(0, 639, 479);
        setpt(1, 640, 0);
        setpt(2, 0, 480);
        setpt(3, 1023, 1023);
        count    = 4'd4;
        in_valid = 1'b1;
        run(0, 0);
        chk("t3_writes",  32'(nwr),       32'd1);
        chk("t3_addr",    32'(last_addr), 32'd307199);
        chk("t3_clip",    32'(clip_cnt),  32'd3);
        chk("t3_dup",     32'(dup_cnt),   32'd0);
        chk("t3_done_at", 32'(done_at),   32'd5);
        @(negedge clk);

        // Five stall cycles on the second point: 3 emits + 5 stalls, done next
        setpt(0, 1, 0);
        setpt(1, 2, 0);
        setpt(2, 3, 0);
        count      = 4'd3;
        stall_addr = 19'd2;
        in_valid   = 1'b1;
        run(2, 5);
        chk("t4_writes",  32'(nwr),       32'd3);
        chk("t4_last",    32'(last_addr), 32'd3);
        chk("t4_done_at", 32'(done_at),   32'd9);
        @(negedge clk);

        // Empty bundle
        count    = 4'd0;
        in_valid = 1'b1;
        run(0, 0);
        chk("t5_writes",  32'(nwr),     32'd0);
        chk("t5_done_at", 32'(done_at), 32'd1);
        @(negedge clk);
        chk("t5_ready",   32'(in_ready), 32'd1);

        // Reset during the third write of an 8-point bundle
        for (int k = 0; k < 8; k++) setpt(k, k, 5);
        count    = 4'd8;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("t6_addr", 32'(wr_addr), 32'(3200 + k));
        end
        rst = 1'b1;
        #1;
        chk("t6_rst_wr_en", 32'(wr_en),    32'd0);
        chk("t6_rst_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_busy",  32'(busy),     32'd0);
        chk("t6_rst_clip",  32'(clip_cnt), 32'd0);
        chk("t6_rst_dup",   32'(dup_cnt),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Next bundle after reset: single point (7,3)
        posiciones = '0;
        setpt(0, 7, 3);
        count    = 4'd1;
        in_valid = 1'b1;
        run(0, 0);
        chk("t6_writes",  32'(nwr),       32'd1);
        chk("t6_addr2",   32'(last_addr), 32'd1927);
        chk("t6_done_at", 32'(done_at),   32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
